response_buffer: RTL

- Sits directly downstream of shared_resource, between it and the sink.
- Absorbs the resource's fire-and-forget (data, id, valid) stream into a first-word-fall-through FIFO.
- Presents responses to the sink with a valid/ready handshake.
- Raises an almost-full flag that upstream uses to stop issuing grants.
- Detects and counts overflows (the resource has no backpressure input), so lost responses are always visible.

---
 rtl/response_buffer_pkg.sv | 21 ++
 rtl/sync_fifo_mem.sv | 25 ++
 rtl/response_buffer.sv | 106 ++++++++++
 3 files changed

// File: rtl/response_buffer_pkg.sv
// Shared types for the response buffer: the stored entry layout and the
// data/id widths taken from the common defines.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

package response_buffer_pkg;

  localparam int DATA_W  = `DATA_WIDTH;
  localparam int ID_W    = `ID_WIDTH;
  localparam int ENTRY_W = DATA_W + ID_W;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array, one synchronous write port and
// a combinational read port so the head is visible without a read cycle.
module sync_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/response_buffer.sv
// First-word-fall-through buffer between shared_resource and the sink. The
// resource cannot be stalled, so pushes into a full buffer are dropped and counted.
module response_buffer
  import response_buffer_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AF_SLACK = 2,
  parameter int DROP_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [ID_W-1:0]            in_id,
  input  logic                       in_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [ID_W-1:0]            out_id,
  output logic                       out_valid,
  input  logic                       in_ready,
  output logic                       out_almost_full,
  output logic                       out_overflow,
  output logic [$clog2(DEPTH+1)-1:0] out_count,
  output logic [DROP_W-1:0]          out_drop_count
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH+1);
  localparam int AF_LEVEL = DEPTH - AF_SLACK;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_almost_full;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;

  logic              w_full;
  logic              w_pop;
  logic              w_accept;
  logic              w_drop;
  logic [CNT_W-1:0]  w_count_next;
  resp_t             w_wr_entry;
  resp_t             w_rd_entry;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_pop    = out_valid & in_ready;
  // A full buffer still accepts when the head leaves in the same cycle:
  // the new entry lands in the slot being freed.
  assign w_accept = in_valid & (~w_full | w_pop);
  assign w_drop   = in_valid & w_full & ~w_pop;

  assign w_count_next = r_count + CNT_W'(w_accept) - CNT_W'(w_pop);

  assign w_wr_entry.id   = in_id;
  assign w_wr_entry.data = in_data;

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_entry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count       <= w_count_next;
      r_almost_full <= (w_count_next >= CNT_W'(AF_LEVEL));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + DROP_W'(1);
      end
    end
  end

  assign out_valid       = (r_count != '0);
  assign out_data        = w_rd_entry.data;
  assign out_id          = w_rd_entry.id;
  assign out_count       = r_count;
  assign out_almost_full = r_almost_full;
  assign out_overflow    = r_overflow;
  assign out_drop_count  = r_drop_count;

endmodule
